vector_issue_queue: RTL

// - Scalar-side producer for the vector unit's instruction input (valid_in / instr_in / pop).
// - Buffers to_vector instructions from the scalar dispatch stage in a small FIFO.
// - Presents the oldest entry to the vector unit and dequeues it when the vector unit asserts pop.
// - Screens every instruction before enqueue, so only legal encodings ever reach the vector datapath.

---
 rtl/vector_issue_queue_pkg.sv | 43 ++++
 rtl/vector_in_assert.sv | 21 ++
 rtl/vector_uop_screen.sv | 36 +++
 rtl/vector_issue_queue.sv | 88 ++++++++
 4 files changed

// File: rtl/vector_issue_queue_pkg.sv
// Shared vector-unit definitions: instruction format, functional-unit codes and
// the legal micro-op sets used by both the issue-side screen and vector-side checks.
package vector_pkg;

  typedef enum logic [1:0] {
    MEM_FU = 2'd0,
    INT_FU = 2'd1,
    FP_FU  = 2'd2,
    FXP_FU = 2'd3
  } vec_fu_e;

  typedef struct packed {
    logic        reconfigure;
    vec_fu_e     fu;
    logic [6:0]  microop;
    logic [21:0] operand;
  } to_vector;

  localparam logic [6:0] VEC_BUBBLE_UOP = 7'b1111111;

  // One bit per micro-op code; a set bit marks the code as legal for that FU.
  localparam logic [127:0] VEC_MEM_UOPS = 128'h0000_FFFF;
  localparam logic [127:0] VEC_INT_UOPS = 128'h00FF_FFFF;
  localparam logic [127:0] VEC_FP_UOPS  = 128'h000F_FFFF;

  localparam logic [1:0] CAUSE_FXP = 2'd0;
  localparam logic [1:0] CAUSE_MEM = 2'd1;
  localparam logic [1:0] CAUSE_INT = 2'd2;
  localparam logic [1:0] CAUSE_FP  = 2'd3;

  function automatic logic vec_uop_legal(input vec_fu_e fu, input logic [6:0] uop);
    logic legal;
    legal = 1'b0;
    case (fu)
      MEM_FU:  legal = VEC_MEM_UOPS[uop];
      INT_FU:  legal = VEC_INT_UOPS[uop];
      FP_FU:   legal = VEC_FP_UOPS[uop];
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/vector_in_assert.sv
// Vector-side input checks on valid_in/instr_in/pop; bound onto the issue queue in simulation.
module vector_in_assert
  import vector_pkg::*;
(
  input logic     clk,
  input logic     rst,
  input logic     valid_in,
  input to_vector instr_in,
  input logic     pop
);

  a_legal_instr: assert property (@(posedge clk) disable iff (rst)
    valid_in |-> (instr_in.fu != FXP_FU &&
                  (instr_in.reconfigure || vec_uop_legal(instr_in.fu, instr_in.microop))));

  a_idle_zero: assert property (@(posedge clk) disable iff (rst)
    !valid_in |-> (instr_in == '0));

  a_pop_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(pop));

endmodule

// File: rtl/vector_uop_screen.sv
// Combinational legality screen applied to every instruction before it is queued.
module vector_uop_screen
  import vector_pkg::*;
(
  input  to_vector   instr,
  output logic       is_bubble,
  output logic       illegal,
  output logic [1:0] cause
);

  logic unused_operand;
  assign unused_operand = ^instr.operand;

  // FXP rejection outranks the bubble pattern; reconfigure bypasses the uop sets.
  always_comb begin
    is_bubble = 1'b0;
    illegal   = 1'b0;
    cause     = '0;
    if (instr.fu == FXP_FU) begin
      illegal = 1'b1;
      cause   = CAUSE_FXP;
    end else if (!instr.reconfigure) begin
      if (instr.microop == VEC_BUBBLE_UOP) begin
        is_bubble = 1'b1;
      end else if (!vec_uop_legal(instr.fu, instr.microop)) begin
        illegal = 1'b1;
        case (instr.fu)
          MEM_FU:  cause = CAUSE_MEM;
          INT_FU:  cause = CAUSE_INT;
          default: cause = CAUSE_FP;
        endcase
      end
    end
  end

endmodule

// File: rtl/vector_issue_queue.sv
// Scalar-side FIFO feeding the vector unit: screens, buffers and presents the
// oldest legal instruction; the vector unit dequeues it with pop.
module vector_issue_queue
  import vector_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  to_vector         push_instr,
  output logic             push_ready,
  output logic             valid_out,
  output to_vector         instr_out,
  input  logic             pop,
  output logic             illegal_drop,
  output logic [1:0]       drop_cause,
  output logic             pop_err,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  to_vector         mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             is_bubble;
  logic             illegal;
  logic [1:0]       cause;
  logic             push_acc;
  logic             write_en;
  logic             pop_acc;

  vector_uop_screen u_screen (
    .instr     (push_instr),
    .is_bubble (is_bubble),
    .illegal   (illegal),
    .cause     (cause)
  );

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign push_ready = (count != FULL_CNT);
  assign valid_out  = (count != '0);
  assign instr_out  = valid_out ? mem[rd_ptr] : '0;
  assign push_acc   = push_valid && push_ready;
  assign write_en   = push_acc && !illegal && !is_bubble;
  assign pop_acc    = pop && valid_out;

  // Storage is not reset; the pointer/count flush makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wr_ptr] <= push_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      illegal_drop <= 1'b0;
      drop_cause   <= '0;
      pop_err      <= 1'b0;
    end else begin
      if (write_en) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_acc) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({write_en, pop_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      illegal_drop <= push_acc && illegal;
      drop_cause   <= (push_acc && illegal) ? cause : '0;
      pop_err      <= pop && !valid_out;
    end
  end

endmodule
